// File: rtl/pipe_expr_pkg.sv
// rtl/pipe_expr_pkg.sv - shared constants, mode encoding and saturation helper for the expression pipeline
package pipe_expr_pkg;

    // Number of register stages between operand acceptance and result presentation
    localparam int PIPE_STAGES = 3;

    // Working width of the clamp helper; callers sign-extend their product into it
    localparam int CLAMP_W = 64;

    // Per-item result mode carried alongside the operands
    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Clamp a signed product into the unsigned range [0, 2^w - 1].
    // The caller truncates the returned value to its own w bits.
    function automatic logic [CLAMP_W-1:0] sat_clamp(
        input logic signed [CLAMP_W-1:0] p,
        input int unsigned               w
    );
        logic signed [CLAMP_W-1:0] lim;
        lim = $signed((CLAMP_W'(1) << w) - CLAMP_W'(1));
        if (p[CLAMP_W-1]) begin
            return '0;
        end else if (p > lim) begin
            return lim;
        end else begin
            return p;
        end
    endfunction

endpackage

// File: rtl/pipe_valid_slice.sv
// rtl/pipe_valid_slice.sv - one valid+data pipeline register with bubble-collapsing handshake
module pipe_valid_slice
    import pipe_expr_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [DW-1:0] up_data,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic [DW-1:0] dn_data
);

    logic          valid_q;
    logic          valid_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;

    // The slice can take a new item when empty or when its current item leaves this cycle
    always_comb begin
        up_ready = !valid_q || dn_ready;
        valid_d  = valid_q;
        data_d   = data_q;
        if (up_ready) begin
            valid_d = up_valid;
            if (up_valid) begin
                data_d = up_data;
            end
        end
    end

    // Valid and data registers; reset discards any resident item
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign dn_valid = valid_q;
    assign dn_data  = data_q;

endmodule

// File: rtl/pipe_expr_stream.sv
// rtl/pipe_expr_stream.sv - flow-controlled 3-stage pipeline computing f = ((a+b)+(c-d))*d
module pipe_expr_stream
    import pipe_expr_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    input  logic         sat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] f,
    output logic         busy
);

    // x3 carries one bit beyond W+2 because a+b+c can reach 3*(2^W-1) when d is small;
    // the final product still fits in 2W+2 signed bits, so nothing is lost downstream.
    localparam int X1W = W + 1;
    localparam int X3W = W + 3;
    localparam int PW  = 2 * W + 4;
    localparam int S1W = 1 + W + X1W + X1W;
    localparam int S2W = 1 + W + X3W;

    logic           s1_ready, s2_ready, s3_ready;
    logic           v1, v2, v3;

    logic [X1W-1:0] x1_c;
    logic [X1W-1:0] x2_c;
    logic [S1W-1:0] s1_in;
    logic [S1W-1:0] s1_out;

    logic           sat1;
    logic [W-1:0]   d1;
    logic [X1W-1:0] x1_1;
    logic [X1W-1:0] x2_1;

    logic [X3W-1:0] x3_c;
    logic [S2W-1:0] s2_in;
    logic [S2W-1:0] s2_out;

    logic           sat2;
    logic [W-1:0]   d2;
    logic [X3W-1:0] x3_2;

    logic signed [PW-1:0] p_c;
    logic [W-1:0]         f_c;

    // Stage-1 operands: unsigned sum and two's-complement difference, both one bit wider than W
    always_comb begin
        x1_c  = {1'b0, a} + {1'b0, b};
        x2_c  = {1'b0, c} - {1'b0, d};
        s1_in = {sat, d, x2_c, x1_c};
    end

    pipe_valid_slice #(.DW(S1W)) u_s1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (in_valid),
        .up_ready (s1_ready),
        .up_data  (s1_in),
        .dn_valid (v1),
        .dn_ready (s2_ready),
        .dn_data  (s1_out)
    );

    assign {sat1, d1, x2_1, x1_1} = s1_out;

    // Stage-2 operand: zero-extend the sum, sign-extend the difference, add in full precision
    always_comb begin
        x3_c  = {2'b00, x1_1} + {{2{x2_1[X1W-1]}}, x2_1};
        s2_in = {sat1, d1, x3_c};
    end

    pipe_valid_slice #(.DW(S2W)) u_s2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (v1),
        .up_ready (s2_ready),
        .up_data  (s2_in),
        .dn_valid (v2),
        .dn_ready (s3_ready),
        .dn_data  (s2_out)
    );

    assign {sat2, d2, x3_2} = s2_out;

    // Final product and wrap/saturate reduction, done before the stage-3 register so only W bits are stored
    always_comb begin
        p_c = $signed({{(PW - X3W){x3_2[X3W-1]}}, x3_2}) * $signed({{(PW - W){1'b0}}, d2});
        if (sat2 == MODE_SAT) begin
            f_c = W'(sat_clamp(CLAMP_W'(p_c), unsigned'(W)));
        end else begin
            f_c = p_c[W-1:0];
        end
    end

    pipe_valid_slice #(.DW(W)) u_s3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (v2),
        .up_ready (s3_ready),
        .up_data  (f_c),
        .dn_valid (v3),
        .dn_ready (out_ready),
        .dn_data  (f)
    );

    logic [PIPE_STAGES-1:0] stage_valid;
    assign stage_valid = {v3, v2, v1};

    assign in_ready  = s1_ready;
    assign out_valid = v3;
    assign busy      = |stage_valid;

endmodule

// File: tb/tb_pipe_expr_stream.sv
// tb/tb_pipe_expr_stream.sv - directed self-checking bench for pipe_expr_stream
`timescale 1ns/1ps
module tb_pipe_expr_stream;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] a, b, c, d;
    logic       sat;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] f;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_expr_stream #(.W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_item(input int ia, input int ib, input int ic, input int id, input logic isat);
        a   = 10'(ia);
        b   = 10'(ib);
        c   = 10'(ic);
        d   = 10'(id);
        sat = isat;
    endtask

    task automatic run_one(input string tag, input int ia, input int ib, input int ic, input int id,
                           input logic isat, input int exp);
        set_item(ia, ib, ic, id, isat);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check({tag, "_early"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_f"}, 32'(f), 32'(exp));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          cnt;
        int          acc_n;
        logic [31:0] q[$];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_item(0, 0, 0, 0, 1'b0);

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_f", 32'(f), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Back-to-back wrap-mode items, first result after the third edge
        set_item(10, 10, 6, 3, 1'b0);
        in_valid = 1'b1;
        tick();
        check("b2b_lat1", 32'(out_valid), 32'd0);
        set_item(5, 5, 5, 3, 1'b0);
        tick();
        check("b2b_lat2", 32'(out_valid), 32'd0);
        set_item(20, 11, 6, 4, 1'b0);
        tick();
        in_valid = 1'b0;
        check("b2b_v1", 32'(out_valid), 32'd1);
        check("b2b_f1", 32'(f), 32'd69);
        tick();
        check("b2b_f2", 32'(f), 32'd36);
        tick();
        check("b2b_f3", 32'(f), 32'd132);
        tick();
        check("b2b_empty", 32'(out_valid), 32'd0);
        check("b2b_busy", 32'(busy), 32'd0);

        // Large positive product: 1997*3 = 5991
        run_one("big_wrap", 1000, 1000, 0, 3, 1'b0, 871);
        run_one("big_sat", 1000, 1000, 0, 3, 1'b1, 1023);
        // Negative product: -5*5 = -25
        run_one("neg_wrap", 0, 0, 0, 5, 1'b0, 999);
        run_one("neg_sat", 0, 0, 0, 5, 1'b1, 0);

        // Backpressure: items (k,0,1,1) give f = k
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_item(1, 0, 1, 1, 1'b0);
        check("stall_rdy1", 32'(in_ready), 32'd1);
        tick();
        set_item(2, 0, 1, 1, 1'b0);
        check("stall_rdy2", 32'(in_ready), 32'd1);
        tick();
        set_item(3, 0, 1, 1, 1'b0);
        check("stall_rdy3", 32'(in_ready), 32'd1);
        tick();
        set_item(4, 0, 1, 1, 1'b0);
        check("stall_full_rdy", 32'(in_ready), 32'd0);
        check("stall_full_valid", 32'(out_valid), 32'd1);
        check("stall_full_f", 32'(f), 32'd1);
        tick();
        check("stall_hold_rdy", 32'(in_ready), 32'd0);
        check("stall_hold_f", 32'(f), 32'd1);
        check("stall_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        #1;
        check("stall_retire_rdy", 32'(in_ready), 32'd1);
        tick();
        set_item(5, 0, 1, 1, 1'b0);
        check("stall_out2", 32'(f), 32'd2);
        tick();
        in_valid = 1'b0;
        check("stall_out3", 32'(f), 32'd3);
        tick();
        check("stall_out4", 32'(f), 32'd4);
        tick();
        check("stall_out5", 32'(f), 32'd5);
        check("stall_out5_valid", 32'(out_valid), 32'd1);
        tick();
        check("stall_drained", 32'(out_valid), 32'd0);

        // Alternating out_ready under continuous in_valid
        k     = 10;
        cnt   = 0;
        acc_n = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            out_ready = (cyc % 2 == 0);
            in_valid  = 1'b1;
            set_item(k, 0, 1, 1, 1'b0);
            #1;
            check("alt_in_ready", 32'(in_ready), 32'((cnt < 3) || out_ready));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("alt_spurious", 32'd1, 32'd0);
                end else begin
                    check("alt_order", 32'(f), q[0]);
                    void'(q.pop_front());
                end
                cnt--;
            end
            if (in_valid && in_ready) begin
                q.push_back(32'(k));
                k++;
                cnt++;
                acc_n++;
            end
            tick();
        end
        check("alt_accepts", 32'(acc_n), 32'd7);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            #1;
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("alt_drain_spurious", 32'd1, 32'd0);
                end else begin
                    check("alt_drain_order", 32'(f), q[0]);
                    void'(q.pop_front());
                end
            end
            tick();
        end
        check("alt_all_out", 32'(q.size()), 32'd0);
        check("alt_busy", 32'(busy), 32'd0);

        // Asynchronous reset with three items in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            set_item(i, 0, 1, 1, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_f", 32'(f), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        run_one("post_rst", 10, 10, 6, 3, 1'b0, 69);
        check("post_rst_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
